uart_rx: RTL

//  UART receiver, the receive-side counterpart of the team's uart_tx. Accepts the same 11-bit frame, LSB-first:

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART constants and receiver state encoding.
//  Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int CLK_PER_BIT_100M = 10417;
    localparam int CLK_PER_BIT_SIM  = 12;
    localparam int FRAME_BITS       = 11;
    localparam int DATA_BITS        = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        MARK    = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Brief    : Two-flop synchroniser followed by a 3-tap majority filter.
//  Revision : 1.0
// ============================================================================
module uart_rx_sync (
    input  logic clk_s,
    input  logic rstn_s,
    input  logic i_rx,
    output logic o_rx_f
);

    logic [1:0] r_sync;
    logic [2:0] r_taps;

    // Reset to the idle level so release never looks like a start edge.
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_sync <= 2'b11;
            r_taps <= 3'b111;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_taps <= {r_taps[1:0], r_sync[1]};
        end
    end

    assign o_rx_f = (r_taps[0] & r_taps[1]) |
                    (r_taps[0] & r_taps[2]) |
                    (r_taps[1] & r_taps[2]);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : UART receiver, 11-bit frame: start, 8 data LSB-first, mark, stop.
//  Revision : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_100M,
    parameter int CNT_W       = 14
) (
    input  logic                 clk_s,
    input  logic                 rstn_s,
    input  logic                 iRX,
    output logic [DATA_BITS-1:0] oDATA,
    output logic                 oVALID,
    output logic                 oFERR,
    output logic                 oBUSY
);

    localparam int               c_IDX_W   = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

    logic                 w_rx_f;
    logic                 w_bit_end;
    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_mark_ok;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;

    uart_rx_sync u_sync (
        .clk_s  (clk_s),
        .rstn_s (rstn_s),
        .i_rx   (iRX),
        .o_rx_f (w_rx_f)
    );

    assign w_bit_end = (r_bit_cnt == c_LAST);

    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_mark_ok <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    if (!w_rx_f) begin
                        r_state <= START;
                    end
                end
                // Half a bit in: confirm the start bit is real, not a glitch.
                START: begin
                    if (r_bit_cnt == c_HALF_M1) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx_f ? IDLE : DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt          <= '0;
                        r_shreg[r_bit_idx] <= w_rx_f;
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_state <= MARK;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                MARK: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_mark_ok <= w_rx_f;
                        r_state   <= STOP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                // Leave at mid-stop so a back-to-back start edge is not missed.
                STOP: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (w_rx_f && r_mark_ok) begin
                            r_data  <= r_shreg;
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= WAIT_HI;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    r_bit_cnt <= '0;
                    if (w_rx_f) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign oDATA  = r_data;
    assign oVALID = r_valid;
    assign oFERR  = r_ferr;
    assign oBUSY  = (r_state != IDLE);

endmodule
`default_nettype wire
